// File: rtl/proto_initiator.sv
// Initiator side of the valid/ready request, valid-done response protocol.
// Issues a burst of requests one at a time and tracks completions and errors.
module proto_initiator #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             req_ready,
    output logic             req_valid,
    input  logic             rsp_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             spurious_err,
    output logic [CNT_W-1:0] txn_count
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        FINISH,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [TMR_W-1:0] timer;

    // Handshake and response are tested before timer expiry so they win in the expiry cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_txn != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    state_nxt = WAIT_RSP;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ERROR;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    state_nxt = (remaining == CNT_W'(1)) ? FINISH : ISSUE;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ERROR;
                end
            end
            FINISH:  state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
            txn_count    <= '0;
            remaining    <= '0;
            timer        <= '0;
        end else begin
            state     <= state_nxt;
            // Outputs are decoded from the next state so they are registered alongside it.
            req_valid <= (state_nxt == ISSUE);
            busy      <= (state_nxt == ISSUE) || (state_nxt == WAIT_RSP);
            done      <= (state_nxt == FINISH);

            if ((state_nxt == state) && ((state == ISSUE) || (state == WAIT_RSP))) begin
                timer <= timer + TMR_W'(1);
            end else begin
                timer <= '0;
            end

            if ((state == IDLE) && start) begin
                remaining    <= num_txn;
                txn_count    <= '0;
                timeout_err  <= 1'b0;
                spurious_err <= 1'b0;
            end

            if ((state == WAIT_RSP) && rsp_valid) begin
                txn_count <= txn_count + CNT_W'(1);
                remaining <= remaining - CNT_W'(1);
            end

            if (state_nxt == ERROR) begin
                timeout_err <= 1'b1;
            end

            // A stray response in the start cycle still flags, overriding the clear.
            if (rsp_valid && (state != WAIT_RSP)) begin
                spurious_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/proto_initiator.md
Name: proto_initiator

Overview:
Initiator end of the single-bit valid/ready request, valid-done response protocol spoken by the team's three-state responders (IDLE→WAIT→DONE).
- On a start command, issues a programmed number of requests one at a time to one responder.
- Waits for each response before issuing the next.
- Counts completions and flags timeouts and spurious responses.
- Sits between a control/sequencer block and a responder under test or in use.

Parameters:
CNT_W, 8, width of transaction count input and completion counter
TIMEOUT, 16, max cycles spent waiting in ISSUE or WAIT_RSP before error (≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset; 0 forces all state/outputs to reset values immediately
start  in  1  one-cycle command to begin a burst; sampled only in IDLE
num_txn  in  CNT_W  number of requests in the burst; sampled with start
req_ready  in  1  responder ready (responder accepts only while high)
req_valid  out  1  request to responder; high only in ISSUE
rsp_valid  in  1  responder completion pulse
busy  out  1  high in ISSUE and WAIT_RSP
done  out  1  one-cycle pulse, burst completed
timeout_err  out  1  sticky; set on timeout, cleared when next start is accepted
spurious_err  out  1  sticky; set on rsp_valid outside WAIT_RSP, cleared when next start is accepted
txn_count  out  CNT_W  completions in current/last burst; cleared when start is accepted

Behaviour:
- Reset (reset=0, async): state=IDLE; req_valid, busy, done, timeout_err, spurious_err = 0; txn_count=0; remaining=0; timer=0.
- States: IDLE, ISSUE, WAIT_RSP, FINISH, ERROR. Registered state. req_valid, busy, done are decoded from state only; no combinational path from inputs.
- IDLE:
  - start=1, num_txn≠0: latch remaining=num_txn; clear txn_count and both error flags; timer=0; go to ISSUE.
  - start=1, num_txn=0: clear count and flags; go to FINISH (done pulses with txn_count=0).
  - Otherwise stay in IDLE.
- ISSUE: req_valid=1.
  - req_ready=1 in the same cycle is the handshake: go to WAIT_RSP, timer=0.
  - Otherwise timer++. When timer==TIMEOUT-1 with no handshake: go to ERROR.
- WAIT_RSP: req_valid=0.
  - rsp_valid=1: txn_count++, remaining--. If remaining was 1, go to FINISH; else go to ISSUE with timer=0.
  - Otherwise timer++. When timer==TIMEOUT-1 with no rsp_valid: go to ERROR.
- FINISH: done=1 for exactly one cycle, then go to IDLE.
- ERROR: timeout_err set (sticky); go to IDLE next cycle. done is not pulsed. txn_count holds the completions made before the timeout.
- Handshake and response take priority over timeout when they fall in the expiry cycle.
- rsp_valid in IDLE, ISSUE, FINISH or ERROR: sets spurious_err. No other effect; it does not count.
- start outside IDLE: ignored. num_txn is not re-sampled mid-burst.
- txn_count does not wrap within a burst, because remaining bounds it to ≤ 2^CNT_W−1.
- Latency with a compliant responder:
  - Handshake at cycle t; rsp_valid at t+2; next handshake at t+3. That is 3 cycles per transaction.
  - Start accepted at cycle 0 gives the first handshake at cycle 1.
  - done pulses at cycle 3N+1.
- Reset asserted mid-burst: immediate return to reset values. No partial response is counted after release.

Test Plan:
1. Start with num_txn=4 against the reference responder model → handshakes at cycles 1,4,7,10; done=1 only at cycle 13; txn_count=4; both error flags 0; busy high cycles 1–12.
2. Start with num_txn=0 → done=1 at cycle 1; txn_count=0; req_valid never asserts.
3. Hold req_ready=0 with TIMEOUT=16 and num_txn=2 → req_valid high 16 cycles; ERROR then IDLE; timeout_err=1; txn_count=0; no done. A next start clears timeout_err.
4. Responder withholds rsp_valid on the 2nd request → timeout in WAIT_RSP; timeout_err=1; txn_count=1.
5. Inject rsp_valid in IDLE and again during ISSUE → spurious_err=1; txn_count unchanged; the burst still completes normally.
6. Assert reset=0 asynchronously mid-WAIT_RSP of a 3-transaction burst → all outputs 0 within the same cycle. After release, start with num_txn=1 completes with txn_count=1, and start pulses applied while busy are ignored.
